// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: serialises DATA_W-bit words LSB first onto a one-bit
// stream and appends one parity bit per word. Back-to-back words run with no
// idle beat between frames.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once ser_valid is high, ser_out and ser_is_par hold steady until
// the beat is consumed. in_ready is high in IDLE, and in PARITY it follows
// ser_ready, so a new word can load on the same edge that consumes the parity
// bit.
module parity_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_is_par,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              acc, acc_nxt;
  logic              done_nxt;

  // The serial outputs decode registered state only, so they cannot change
  // while a beat is stalled.
  assign ser_valid  = (state != IDLE);
  assign ser_is_par = (state == PARITY);
  assign busy       = (state != IDLE);
  assign ser_out    = (state == SHIFT)  ? shreg[0] :
                      (state == PARITY) ? acc      : 1'b0;

  // Next-state, datapath update and in_ready. Defaults hold every register.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    done_nxt  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_nxt = in_data;
          cnt_nxt   = '0;
          acc_nxt   = ODD_PARITY;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          acc_nxt   = acc ^ shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        in_ready = ser_ready;
        if (ser_ready) begin
          done_nxt = 1'b1;
          if (in_valid) begin
            // The next word loads on this same edge, so its bit 0 follows
            // the parity beat with no bubble.
            shreg_nxt = in_data;
            cnt_nxt   = '0;
            acc_nxt   = ODD_PARITY;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      acc        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl. Two instances (even and odd parity) share the
// same stimulus. A word-level model checks every output of both on every
// cycle, and directed tests pin whole frames against literal values.
module tb_parity_frame_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] in_data   = '0;
  logic         in_valid  = 1'b0;
  logic         ser_ready = 1'b0;

  logic in_ready_e, ser_out_e, ser_valid_e, ser_is_par_e, frame_done_e, busy_e;
  logic in_ready_o, ser_out_o, ser_valid_o, ser_is_par_o, frame_done_o, busy_o;

  parity_frame_ctrl #(.DATA_W(W), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_e), .ser_out(ser_out_e), .ser_valid(ser_valid_e),
    .ser_ready(ser_ready), .ser_is_par(ser_is_par_e),
    .frame_done(frame_done_e), .busy(busy_e)
  );

  parity_frame_ctrl #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_o), .ser_out(ser_out_o), .ser_valid(ser_valid_o),
    .ser_ready(ser_ready), .ser_is_par(ser_is_par_o),
    .frame_done(frame_done_o), .busy(busy_o)
  );

  // ---------------- check helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Beat b of a frame: data bit b for b < W, else XOR of all bits XOR odd.
  function automatic logic exp_bit(input logic [W-1:0] w, input int b, input logic odd);
    if (b < W) return w[b];
    return (^w) ^ odd;
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];   // words accepted, frame at head is on the line
  int           beat = 0;   // beats of the head frame already consumed
  logic         done_exp = 1'b0;
  logic         has, exp_rdy, eb;
  int           accepted = 0;
  int           done_cnt = 0;
  logic [W:0]   cap_e = '0, cap_o = '0, last_e = '0, last_o = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      beat = 0;
      done_exp = 1'b0;
    end else begin
      has     = (exp_q.size() != 0);
      exp_rdy = !has || (beat == W && ser_ready);
      check_bit("in_ready_e",   in_ready_e,   exp_rdy);
      check_bit("in_ready_o",   in_ready_o,   exp_rdy);
      check_bit("ser_valid_e",  ser_valid_e,  has);
      check_bit("ser_valid_o",  ser_valid_o,  has);
      check_bit("busy_e",       busy_e,       has);
      check_bit("busy_o",       busy_o,       has);
      check_bit("ser_is_par_e", ser_is_par_e, has && beat == W);
      check_bit("ser_is_par_o", ser_is_par_o, has && beat == W);
      check_bit("frame_done_e", frame_done_e, done_exp);
      check_bit("frame_done_o", frame_done_o, done_exp);
      if (has) begin
        eb = exp_bit(exp_q[0], beat, 1'b0);
        check_bit("ser_out_e", ser_out_e, eb);
        eb = exp_bit(exp_q[0], beat, 1'b1);
        check_bit("ser_out_o", ser_out_o, eb);
      end else begin
        check_bit("ser_out_e_idle", ser_out_e, 1'b0);
        check_bit("ser_out_o_idle", ser_out_o, 1'b0);
      end
      if (frame_done_e === 1'b1) done_cnt++;
      done_exp = 1'b0;
      if (has && ser_ready) begin
        cap_e[beat] = ser_out_e;
        cap_o[beat] = ser_out_o;
        if (beat == W) begin
          last_e = cap_e;
          last_o = cap_o;
          void'(exp_q.pop_front());
          beat = 0;
          done_exp = 1'b1;
        end else begin
          beat++;
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(in_data);
        accepted++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;
  int done_cyc = 0;

  // Present w and wait for it to be accepted; returns at posedge+1 of the
  // accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready_e !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_bit("send_wait_bound", n < 200, 1'b1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (frame_done_e !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_bit("done_wait_bound", n < 200, 1'b1);
    done_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random tests ----------------
  initial begin
    int a1;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_ser_valid",  ser_valid_e,  1'b0);
    check_bit("rst_ser_out",    ser_out_e,    1'b0);
    check_bit("rst_ser_is_par", ser_is_par_e, 1'b0);
    check_bit("rst_frame_done", frame_done_e, 1'b0);
    check_bit("rst_busy",       busy_e,       1'b0);
    check_bit("rst_in_ready",   in_ready_e,   1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: 0xA5, even parity 0, frame_done 10 cycles after acceptance
    ser_ready = 1'b1;
    send(8'hA5);
    in_valid = 1'b0;
    wait_done();
    check_val("a5_done_latency", 32'(done_cyc - acc_cyc), 32'd10);
    check_val("a5_frame_e", 32'(last_e), 32'h0A5);
    check_val("a5_frame_o", 32'(last_o), 32'h1A5);

    // 2: 0x07 and 0x00
    send(8'h07);
    in_valid = 1'b0;
    wait_done();
    check_val("07_frame_e", 32'(last_e), 32'h107);
    check_val("07_frame_o", 32'(last_o), 32'h007);
    send(8'h00);
    in_valid = 1'b0;
    wait_done();
    check_val("00_frame_e", 32'(last_e), 32'h000);
    check_val("00_frame_o", 32'(last_o), 32'h100);

    // 3: back-to-back 0xFF then 0x01 with in_valid held high
    send(8'hFF);
    a1 = acc_cyc;
    send(8'h01);
    in_valid = 1'b0;
    check_val("b2b_accept_gap", 32'(acc_cyc - a1), 32'd9);
    wait_done();
    check_val("ff_frame_e", 32'(last_e), 32'h0FF);
    check_val("ff_frame_o", 32'(last_o), 32'h1FF);
    wait_done();
    check_val("01_frame_e", 32'(last_e), 32'h101);
    check_val("01_frame_o", 32'(last_o), 32'h001);

    // 4: stalls mid-SHIFT and during PARITY
    send(8'h5A);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ser_ready = 1'b1;
    n = 0;
    while (ser_is_par_e !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_bit("par_wait_bound", n < 50, 1'b1);
    ser_ready = 1'b0;
    in_data   = 8'hC3;
    in_valid  = 1'b1;
    #1;
    check_bit("par_stall_in_ready", in_ready_e, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_bit("par_stall_is_par", ser_is_par_e & ser_valid_e, 1'b1);
      check_bit("par_stall_out_e", ser_out_e, 1'b0);
      check_bit("par_stall_out_o", ser_out_o, 1'b1);
    end
    ser_ready = 1'b1;
    send(8'hC3);
    in_valid = 1'b0;
    wait_done();
    check_val("5a_frame_e", 32'(last_e), 32'h05A);
    check_val("5a_frame_o", 32'(last_o), 32'h15A);
    wait_done();
    check_val("c3_frame_e", 32'(last_e), 32'h0C3);
    check_val("c3_frame_o", 32'(last_o), 32'h1C3);

    // 5: reset after 4 bits of 0x3C, then a clean 0x81 frame
    send(8'h3C);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_bit("pre_rst_busy", busy_e, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("async_rst_ser_valid", ser_valid_e, 1'b0);
    check_bit("async_rst_is_par",    ser_is_par_e, 1'b0);
    check_bit("async_rst_ser_out",   ser_out_e, 1'b0);
    check_bit("async_rst_busy",      busy_e, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_bit("post_rst_busy",     busy_e, 1'b0);
    check_bit("post_rst_in_ready", in_ready_e, 1'b1);
    send(8'h81);
    in_valid = 1'b0;
    wait_done();
    check_val("81_frame_e", 32'(last_e), 32'h081);
    check_val("81_frame_o", 32'(last_o), 32'h181);

    // 6: 1000 random words with random gaps and stalls
    accepted = 0;
    done_cnt = 0;
    n = 0;
    while (accepted < 1000 && n < 40000) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    check_bit("rand_cycle_bound", n < 40000, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);
    check_val("rand_accepted", 32'(accepted), 32'd1000);
    check_val("rand_done_count", 32'(done_cnt), 32'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
Sequencer that serialises parallel data words into a bit stream and appends one parity bit per word.
- Upstream handshake: valid/ready. Downstream handshake: valid/ready, one bit per beat.
- Owns the running-parity accumulator and the bit counter; sits between a word source and a serial line driver.
- Back-to-back frames run at full throughput with no idle cycles.

Parameters:
DATA_W, 8, bits per data word (2..32).
ODD_PARITY, 0, 0 = even parity (data plus parity bit has an even count of ones); 1 = odd parity.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  DATA_W  word to serialise; sampled on an input handshake.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a word this cycle.
ser_out  out  1  current serial bit.
ser_valid  out  1  ser_out is valid.
ser_ready  in  1  downstream consumes ser_out this cycle.
ser_is_par  out  1  current beat is the parity bit.
frame_done  out  1  one-cycle pulse; parity beat consumed.
busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync to clk on release):
  - state = IDLE; shift register, bit counter and parity accumulator = 0.
  - ser_valid = 0, ser_is_par = 0, frame_done = 0, busy = 0.
  - ser_out = 0 while ser_valid = 0.
  - rst asserted mid-frame aborts the frame immediately; the partial frame is discarded and nothing is replayed.
- Handshakes:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - ser_valid, ser_out and ser_is_par are registered and stay stable while ser_valid && !ser_ready.
- FSM states: IDLE, SHIFT, PARITY.
  - IDLE:
    - in_ready = 1.
    - On an input transfer: load shift register with in_data, bit counter = 0, accumulator = ODD_PARITY, go to SHIFT.
    - The first data bit appears on ser_out the cycle after acceptance. Latency from accept to first serial beat is 1 cycle.
  - SHIFT:
    - ser_valid = 1; ser_out = shift register bit 0 (LSB first); in_ready = 0.
    - On a serial transfer: accumulator ^= ser_out, shift right by 1, counter += 1.
    - When the transfer consumes bit DATA_W-1, go to PARITY.
    - No serial transfer means no state change (stall).
  - PARITY:
    - ser_valid = 1; ser_is_par = 1; ser_out = accumulator (the final value after all DATA_W bits).
    - in_ready = ser_ready (combinational), allowing a new word to be accepted in the same cycle the parity bit is consumed.
    - On a serial transfer: frame_done pulses in the next cycle (registered).
      - If an input transfer happens in the same cycle: load the new word and go to SHIFT, so the next cycle carries bit 0 of the new word (zero bubbles).
      - Otherwise go to IDLE.
- Arithmetic and width:
  - Counter width = clog2(DATA_W) + 1; it never wraps within a frame.
  - Parity bit = XOR of all data bits, XOR ODD_PARITY.
- Frame length: exactly DATA_W + 1 serial beats per word.
- in_valid deasserted or toggling outside IDLE/PARITY is ignored; in_data is don't-care except on a transfer.
- busy = (state != IDLE).
- Outputs never contain X after reset.

Test Plan:
1. DATA_W=8, ODD_PARITY=0, ser_ready=1, send 0xA5 → ser_out sequence 1,0,1,0,0,1,0,1 then parity 0 with ser_is_par=1; frame_done pulses once, 10 cycles after acceptance.
2. ODD_PARITY=1, send 0x07 → bits 1,1,1,0,0,0,0,0, parity 0. Send 0x00 → parity 1.
3. Back-to-back: in_valid held high with 0xFF then 0x01, ser_ready=1 → 18 contiguous beats with no ser_valid gap; parities 0 then 1; in_ready high only in IDLE and on the parity-transfer cycle.
4. Stall: drop ser_ready for 3 cycles mid-SHIFT and again during PARITY → ser_out, ser_valid and ser_is_par held stable; the final bitstream is identical to the unstalled run; in_ready stays 0 during the PARITY stall.
5. Reset mid-frame: assert rst after 4 bits of 0x3C → ser_valid drops in the same cycle without waiting for clk; after release, busy=0 and in_ready=1. Sending 0x81 then yields a clean frame with parity 0.
6. Random words with random ser_ready and in_valid gaps for 1000 frames → a scoreboard checks bit order, parity per ODD_PARITY, and that the frame_done count equals the number of accepted words.
